// File: rtl/banked_reg_file_pkg.sv
// Shared parameter defaults, stream FSM state encoding and address-width helper
// for the banked register file.
package banked_reg_file_pkg;

    localparam int N_W_DEF    = 16;
    localparam int N_REGS_DEF = 16;
    localparam int B_W_DEF    = 1536;
    localparam int B_REGS_DEF = 3;
    localparam int CHUNK_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        UNLOAD,
        LOAD,
        DONE
    } st_state_t;

    // Address width for a bank of n entries, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int beats_of(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/banked_reg_file_if.sv
// Beat-serial bitmap stream: so_* carries register data out, si_* brings memory data in.
interface banked_reg_file_if #(
    parameter int CHUNK = 16
);
    logic [CHUNK-1:0] so_data;
    logic             so_valid;
    logic             so_ready;
    logic [CHUNK-1:0] si_data;
    logic             si_valid;
    logic             si_ready;

    modport master (
        output so_data, so_valid, si_ready,
        input  so_ready, si_data, si_valid
    );

    modport slave (
        input  so_data, so_valid, si_ready,
        output so_ready, si_data, si_valid
    );
endinterface

// File: rtl/banked_reg_file_stream_ctrl.sv
// Stream engine: walks one bitmap register beat by beat, LSB chunk first,
// and tells the storage which slice to write on a load.
module bm_stream_ctrl
    import banked_reg_file_pkg::*;
#(
    parameter int B_REGS = B_REGS_DEF,
    parameter int CHUNK  = CHUNK_DEF,
    parameter int BEATS  = beats_of(B_W_DEF, CHUNK_DEF),
    parameter int BW_A   = addr_w(B_REGS),
    parameter int CW     = addr_w(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_dir,
    input  logic [BW_A-1:0]   i_addr,
    input  logic [CHUNK-1:0]  i_unload_chunk,
    banked_reg_file_if.master s_if,
    output logic              o_busy,
    output logic              o_done,
    output logic [BW_A-1:0]   o_addr,
    output logic [CW-1:0]     o_cnt,
    output logic              o_slice_we
);

    st_state_t       r_state;
    logic [BW_A-1:0] r_addr;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_so_valid;
    logic            r_si_ready;
    logic            w_last;

    assign w_last = (r_cnt == CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_so_valid <= 1'b0;
            r_si_ready <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        // An out-of-range target completes at once without touching data.
                        if (int'(i_addr) < B_REGS) begin
                            r_addr <= i_addr;
                            r_cnt  <= '0;
                            r_busy <= 1'b1;
                            if (i_dir) begin
                                r_state    <= LOAD;
                                r_si_ready <= 1'b1;
                            end else begin
                                r_state    <= UNLOAD;
                                r_so_valid <= 1'b1;
                            end
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                UNLOAD: begin
                    if (r_so_valid && s_if.so_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state    <= DONE;
                            r_so_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (s_if.si_valid && r_si_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state    <= DONE;
                            r_si_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_if.so_data  = i_unload_chunk;
    assign s_if.so_valid = r_so_valid;
    assign s_if.si_ready = r_si_ready;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_addr        = r_addr;
    assign o_cnt         = r_cnt;
    assign o_slice_we    = (r_state == LOAD) && r_si_ready && s_if.si_valid;

endmodule

// File: rtl/banked_reg_file.sv
// CPU register file: narrow GPR bank with bypassed dual read, wide bitmap bank
// with full-width access and a beat-serial stream port to bitmap memory.
module banked_reg_file
    import banked_reg_file_pkg::*;
#(
    parameter int N_W    = N_W_DEF,
    parameter int N_REGS = N_REGS_DEF,
    parameter int B_W    = B_W_DEF,
    parameter int B_REGS = B_REGS_DEF,
    parameter int CHUNK  = CHUNK_DEF,
    parameter int AW     = addr_w(N_REGS),
    parameter int BW_A   = addr_w(B_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     i_rd_addr_1,
    input  logic [AW-1:0]     i_rd_addr_2,
    output logic [N_W-1:0]    o_rd_data_1,
    output logic [N_W-1:0]    o_rd_data_2,
    input  logic              i_wr,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [N_W-1:0]    i_wr_data,
    input  logic [BW_A-1:0]   i_rbm_addr,
    output logic [B_W-1:0]    o_rbm_data,
    input  logic              i_wbm,
    input  logic [BW_A-1:0]   i_wbm_addr,
    input  logic [B_W-1:0]    i_wbm_data,
    input  logic              i_st_start,
    input  logic              i_st_dir,
    input  logic [BW_A-1:0]   i_st_addr,
    output logic              o_st_busy,
    output logic              o_st_done,
    banked_reg_file_if.master s_if
);

    localparam int BEATS = beats_of(B_W, CHUNK);
    localparam int CW    = addr_w(BEATS);

    logic [N_W-1:0]   r_regs [N_REGS];
    logic [B_W-1:0]   r_bm   [B_REGS];
    logic [BW_A-1:0]  w_st_addr;
    logic [CW-1:0]    w_cnt;
    logic             w_slice_we;
    logic             w_wr_ok;
    logic             w_wbm_ok;
    logic [CHUNK-1:0] w_unload_chunk;

    assign w_wr_ok  = i_wr && (int'(i_wr_addr) < N_REGS);
    // The register being streamed is owned by the engine until it finishes.
    assign w_wbm_ok = i_wbm && (int'(i_wbm_addr) < B_REGS)
                      && !(o_st_busy && (i_wbm_addr == w_st_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
            for (int j = 0; j < B_REGS; j++) r_bm[j] <= '0;
        end else begin
            if (w_wr_ok) r_regs[i_wr_addr] <= i_wr_data;
            if (w_wbm_ok) r_bm[i_wbm_addr] <= i_wbm_data;
            if (w_slice_we) r_bm[w_st_addr][w_cnt*CHUNK +: CHUNK] <= s_if.si_data;
        end
    end

    always_comb begin
        o_rd_data_1 = (int'(i_rd_addr_1) < N_REGS) ? r_regs[i_rd_addr_1] : '0;
        o_rd_data_2 = (int'(i_rd_addr_2) < N_REGS) ? r_regs[i_rd_addr_2] : '0;
        if (w_wr_ok && (i_wr_addr == i_rd_addr_1)) o_rd_data_1 = i_wr_data;
        if (w_wr_ok && (i_wr_addr == i_rd_addr_2)) o_rd_data_2 = i_wr_data;
        o_rbm_data     = (int'(i_rbm_addr) < B_REGS) ? r_bm[i_rbm_addr] : '0;
        w_unload_chunk = r_bm[w_st_addr][w_cnt*CHUNK +: CHUNK];
    end

    bm_stream_ctrl #(
        .B_REGS (B_REGS),
        .CHUNK  (CHUNK),
        .BEATS  (BEATS),
        .BW_A   (BW_A),
        .CW     (CW)
    ) u_stream (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_st_start),
        .i_dir          (i_st_dir),
        .i_addr         (i_st_addr),
        .i_unload_chunk (w_unload_chunk),
        .s_if           (s_if),
        .o_busy         (o_st_busy),
        .o_done         (o_st_done),
        .o_addr         (w_st_addr),
        .o_cnt          (w_cnt),
        .o_slice_we     (w_slice_we)
    );

endmodule
